// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared widths and constants for the register-file write-port arbiter
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 64;

    // Writes to this register are accepted but never reach the register file.
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_port_arbiter_mux.sv
// rtl/wb_port_arbiter_mux.sv - 64-bit 2:1 data select used by the write-port arbiter
//
// Ports:
//   a    - data selected when ctrl is 1
//   b    - data selected when ctrl is 0
//   ctrl - select
//   y    - selected data
module mux_64bit
    import wb_port_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              ctrl,
    output logic [DATA_W-1:0] y
);

    assign y = ctrl ? a : b;

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - bounded-burst arbiter for the single register-file write port
//
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   a_valid/a_waddr/a_wdata/a_ready - load-path requester (favoured)
//   b_valid/b_waddr/b_wdata/b_ready - ALU/mul-div requester
//   rf_we/rf_waddr/rf_wdata         - registered register-file write port
//   burst_cnt                       - consecutive A grants taken while B waits
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic                  b_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [3:0]            burst_cnt
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    logic                  grant_a;
    logic                  grant_b;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] sel_waddr;
    logic [DATA_W-1:0]     sel_wdata;
    logic [3:0]            cnt_q;

    // A wins unless B is waiting and A has used up its burst allowance.
    // Ready is granted purely from valids and the counter, so it never
    // loops back through the requester's own ready.
    always_comb begin
        grant_a = a_valid && (!b_valid || (cnt_q < MAX_CNT));
        grant_b = b_valid && !grant_a;
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign xfer      = grant_a || grant_b;
    assign burst_cnt = cnt_q;

    // Count only A grants that made B wait; B being served or absent
    // ends the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (!b_valid || grant_b) begin
            cnt_q <= 4'd0;
        end else if (grant_a && (cnt_q < MAX_CNT)) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign sel_waddr = grant_a ? a_waddr : b_waddr;

    mux_64bit u_data_mux (
        .a    (a_wdata),
        .b    (b_wdata),
        .ctrl (grant_a),
        .y    (sel_wdata)
    );

    // Address/data track every accepted transfer (including r0) and hold
    // on idle cycles; only the enable filters out register 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= xfer && (sel_waddr != REG_ZERO);
            if (xfer) begin
                rf_waddr <= sel_waddr;
                rf_wdata <= sel_wdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_waddr;
    logic [63:0] a_wdata;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_waddr;
    logic [63:0] b_wdata;
    logic        b_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [3:0]  burst_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_waddr   (a_waddr),
        .a_wdata   (a_wdata),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_waddr   (b_waddr),
        .b_wdata   (b_wdata),
        .b_ready   (b_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .burst_cnt (burst_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        a_valid = 1'b0;
        a_waddr = '0;
        a_wdata = '0;
        b_valid = 1'b0;
        b_waddr = '0;
        b_wdata = '0;
        tick();
        tick();

        // Reset state
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_cnt", burst_cnt, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        rst = 1'b0;
        tick();

        // Single A write
        a_valid = 1'b1;
        a_waddr = 5'd7;
        a_wdata = 64'hDEAD_BEEF_0000_0001;
        #1;
        chk("single_a_ready", a_ready, 1);
        chk("single_b_ready", b_ready, 0);
        tick();
        idle_inputs();
        chk("single_we", rf_we, 1);
        chk("single_waddr", rf_waddr, 7);
        chk("single_wdata", rf_wdata, 64'hDEAD_BEEF_0000_0001);
        tick();
        chk("single_idle_we", rf_we, 0);
        chk("single_idle_hold_addr", rf_waddr, 7);
        chk("single_idle_hold_data", rf_wdata, 64'hDEAD_BEEF_0000_0001);

        // Continuous contention: A,A,A,A,B repeated, count 0..4
        a_valid = 1'b1; a_waddr = 5'd1; a_wdata = 64'hAAAA;
        b_valid = 1'b1; b_waddr = 5'd2; b_wdata = 64'hBBBB;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("cont_cnt_%0d", i), burst_cnt, 64'(i % 5));
            chk($sformatf("cont_a_ready_%0d", i), a_ready, (i % 5) != 4);
            chk($sformatf("cont_b_ready_%0d", i), b_ready, (i % 5) == 4);
            tick();
            chk($sformatf("cont_we_%0d", i), rf_we, 1);
            chk($sformatf("cont_waddr_%0d", i), rf_waddr, ((i % 5) == 4) ? 2 : 1);
            chk($sformatf("cont_wdata_%0d", i), rf_wdata, ((i % 5) == 4) ? 64'hBBBB : 64'hAAAA);
        end
        idle_inputs();
        #1;
        chk("cont_after_b_cnt", burst_cnt, 0);
        tick();

        // Register-zero write from B
        b_valid = 1'b1; b_waddr = 5'd0; b_wdata = 64'h5;
        #1;
        chk("r0_b_ready", b_ready, 1);
        tick();
        idle_inputs();
        chk("r0_we", rf_we, 0);
        chk("r0_waddr", rf_waddr, 0);
        chk("r0_wdata", rf_wdata, 64'h5);
        tick();

        // B drops mid-burst: count clears and a fresh 4-grant burst follows
        a_valid = 1'b1; a_waddr = 5'd3; a_wdata = 64'h33;
        b_valid = 1'b1; b_waddr = 5'd4; b_wdata = 64'h44;
        tick();
        tick();
        chk("drop_cnt_2", burst_cnt, 2);
        b_valid = 1'b0;
        #1;
        chk("drop_a_ready", a_ready, 1);
        tick();
        chk("drop_cnt_cleared", burst_cnt, 0);
        b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("drop_burst_a_%0d", i), a_ready, 1);
            chk($sformatf("drop_burst_cnt_%0d", i), burst_cnt, 64'(i));
            tick();
        end
        #1;
        chk("drop_burst_b_ready", b_ready, 1);
        chk("drop_burst_cnt_max", burst_cnt, 4);
        tick();
        idle_inputs();
        tick();

        // Reset mid-stream while A is granted with B waiting
        a_valid = 1'b1; a_waddr = 5'd9; a_wdata = 64'h99;
        b_valid = 1'b1; b_waddr = 5'd10; b_wdata = 64'h1010;
        tick();
        tick();
        chk("mrst_cnt_pre", burst_cnt, 2);
        rst = 1'b1;
        #1;
        chk("mrst_a_ready", a_ready, 1);
        tick();
        rst = 1'b0;
        idle_inputs();
        chk("mrst_we", rf_we, 0);
        chk("mrst_cnt", burst_cnt, 0);
        chk("mrst_waddr", rf_waddr, 0);
        tick();
        chk("mrst_we_after", rf_we, 0);

        // Back-to-back alternating one-hot writes, no bubbles
        for (int i = 0; i < 8; i++) begin
            a_valid = (i % 2) == 0;
            b_valid = (i % 2) == 1;
            a_waddr = 5'(11 + i); a_wdata = 64'(100 + i);
            b_waddr = 5'(11 + i); b_wdata = 64'(200 + i);
            #1;
            chk($sformatf("b2b_ready_%0d", i), (i % 2) == 0 ? a_ready : b_ready, 1);
            tick();
            chk($sformatf("b2b_we_%0d", i), rf_we, 1);
            chk($sformatf("b2b_waddr_%0d", i), rf_waddr, 11 + i);
            chk($sformatf("b2b_wdata_%0d", i), rf_wdata, (i % 2) == 0 ? 100 + i : 200 + i);
        end
        idle_inputs();
        tick();
        chk("b2b_end_we", rf_we, 0);
        chk("b2b_end_cnt", burst_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
